// File: rtl/conv_stream_ctrl_if.sv
// Stream handshake bundle for conv_stream_ctrl: X and F input streams,
// F memory write port, Y output stream, capture strobe and job-done pulse.
interface conv_stream_ctrl_if #(
    parameter int F_SIZE = 32
) ();
    localparam int AW = $clog2(F_SIZE);

    logic          s_valid_x;
    logic          s_ready_x;
    logic          x_wr_en;
    logic          s_valid_f;
    logic          s_ready_f;
    logic          f_wr_en;
    logic [AW-1:0] f_addr;
    logic          y_capture_en;
    logic          m_valid_y;
    logic          m_ready_y;
    logic          conv_done;

    modport slave (
        input  s_valid_x, s_valid_f, m_ready_y,
        output s_ready_x, x_wr_en, s_ready_f, f_wr_en, f_addr,
        output y_capture_en, m_valid_y, conv_done
    );

    modport master (
        output s_valid_x, s_valid_f, m_ready_y,
        input  s_ready_x, x_wr_en, s_ready_f, f_wr_en, f_addr,
        input  y_capture_en, m_valid_y, conv_done
    );
endinterface

// File: rtl/conv_stream_ctrl.sv
// Convolution stream controller: fills X window and F memory, then emits
// one Y per new X sample (X_SIZE-F_SIZE+1 per job) with valid/ready flow.
// Ports: clk, reset (sync, active-high), bus (conv_stream_ctrl_if.slave).
// Option: define CONV_STREAM_CTRL_PREFETCH_EN to accept the next X during OUT.
module conv_stream_ctrl #(
    parameter int X_SIZE = 128,
    parameter int F_SIZE = 32
) (
    input logic               clk,
    input logic               reset,
    conv_stream_ctrl_if.slave bus
);
    localparam int XW = $clog2(X_SIZE + 1);
    localparam int FW = $clog2(F_SIZE + 1);
    localparam int AW = $clog2(F_SIZE);

    localparam logic [XW-1:0] X_MAX = XW'(X_SIZE);
    localparam logic [XW-1:0] X_F   = XW'(F_SIZE);
    localparam logic [FW-1:0] F_MAX = FW'(F_SIZE);

    typedef enum logic [2:0] {
        FILL,
        CAPTURE,
        OUT,
        ADVANCE,
        DONE
    } state_t;

    state_t        state, state_nxt;
    logic [XW-1:0] x_count, x_nxt;
    logic [FW-1:0] f_count, f_nxt;
    logic          ready_x, ready_f;
    logic          x_wr, f_wr;
    logic          cap, mv, done;

`ifdef CONV_STREAM_CTRL_PREFETCH_EN
    logic          pf, pf_nxt;
`endif

    always_comb begin
        ready_x   = 1'b0;
        ready_f   = 1'b0;
        cap       = 1'b0;
        mv        = 1'b0;
        done      = 1'b0;
        state_nxt = state;
`ifdef CONV_STREAM_CTRL_PREFETCH_EN
        pf_nxt    = pf;
`endif

        unique case (state)
            FILL: begin
                ready_x = x_count < X_F;
                ready_f = f_count < F_MAX;
            end
            CAPTURE: cap = 1'b1;
            OUT: begin
                mv = 1'b1;
`ifdef CONV_STREAM_CTRL_PREFETCH_EN
                ready_x = (x_count < X_MAX) && !pf;
`endif
            end
            ADVANCE: ready_x = 1'b1;
            DONE:    done    = 1'b1;
            default: ;
        endcase

        // outputs are forced low for the whole reset cycle
        if (reset) begin
            ready_x = 1'b0;
            ready_f = 1'b0;
            cap     = 1'b0;
            mv      = 1'b0;
            done    = 1'b0;
        end

        x_wr  = bus.s_valid_x & ready_x;
        f_wr  = bus.s_valid_f & ready_f;
        x_nxt = x_count + XW'(x_wr);
        f_nxt = f_count + FW'(f_wr);

        unique case (state)
            FILL: begin
                // look at post-write counts so CAPTURE follows the last write
                if (x_nxt == X_F && f_nxt == F_MAX)
                    state_nxt = CAPTURE;
            end
            CAPTURE: state_nxt = OUT;
            OUT: begin
`ifdef CONV_STREAM_CTRL_PREFETCH_EN
                if (bus.m_ready_y) begin
                    if (pf || x_wr) begin
                        state_nxt = CAPTURE;
                        pf_nxt    = 1'b0;
                    end else if (x_count == X_MAX) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = ADVANCE;
                    end
                end else if (x_wr) begin
                    pf_nxt = 1'b1;
                end
`else
                if (bus.m_ready_y)
                    state_nxt = (x_count == X_MAX) ? DONE : ADVANCE;
`endif
            end
            ADVANCE: begin
                if (x_wr)
                    state_nxt = CAPTURE;
            end
            DONE: begin
                state_nxt = FILL;
                x_nxt     = '0;
                f_nxt     = '0;
`ifdef CONV_STREAM_CTRL_PREFETCH_EN
                pf_nxt    = 1'b0;
`endif
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FILL;
            x_count <= '0;
            f_count <= '0;
`ifdef CONV_STREAM_CTRL_PREFETCH_EN
            pf      <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            x_count <= x_nxt;
            f_count <= f_nxt;
`ifdef CONV_STREAM_CTRL_PREFETCH_EN
            pf      <= pf_nxt;
`endif
        end
    end

    assign bus.s_ready_x    = ready_x;
    assign bus.s_ready_f    = ready_f;
    assign bus.x_wr_en      = x_wr;
    assign bus.f_wr_en      = f_wr;
    assign bus.f_addr       = reset ? '0 : f_count[AW-1:0];
    assign bus.y_capture_en = cap;
    assign bus.m_valid_y    = mv;
    assign bus.conv_done    = done;
endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Self-checking bench for conv_stream_ctrl: directed vector table plus
// randomized jobs checked against a sample-count based reference model.
module tb_conv_stream_ctrl;
    localparam int X  = 128;
    localparam int F  = 32;
    localparam int NY = X - F + 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    conv_stream_ctrl_if #(.F_SIZE(F)) bus ();

    conv_stream_ctrl #(.X_SIZE(X), .F_SIZE(F)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // reference model: counts of accepted samples and produced outputs
    int xa = 0, fa = 0, ycap = 0, yhs = 0, jobs = 0;
    bit trig = 0, p_cap = 0, p_mv = 0, p_my = 0, done_due = 0;

    function automatic int avail(input int xs, input int fs);
        return (fs == F && xs >= F) ? xs - F + 1 : 0;
    endfunction

    always @(negedge clk) begin
        bit e_cap, e_mv, e_done, e_rx, e_rf, filling, acc_x, acc_f, hs;
        int owed;
        if (reset) begin
            chk("reset_outs",
                int'({bus.s_ready_x, bus.s_ready_f, bus.x_wr_en,
                      bus.f_wr_en, bus.y_capture_en, bus.m_valid_y,
                      bus.conv_done, bus.f_addr}), 0);
            xa = 0; fa = 0; ycap = 0; yhs = 0;
            trig = 0; p_cap = 0; p_mv = 0; p_my = 0; done_due = 0;
        end else begin
            e_cap   = trig;
            e_mv    = p_cap || (p_mv && !p_my);
            e_done  = done_due;
            owed    = avail(xa, fa) - ycap;
            filling = (avail(xa, fa) == 0);
            if (filling)
                e_rx = (xa < F);
            else if (e_mv)
`ifdef CONV_STREAM_CTRL_PREFETCH_EN
                e_rx = (xa < X) && (owed == 0);
`else
                e_rx = 1'b0;
`endif
            else
                e_rx = !e_cap && !e_done && (xa < X);
            e_rf = (fa < F);

            chk("y_capture_en", bus.y_capture_en, e_cap);
            chk("m_valid_y", bus.m_valid_y, e_mv);
            chk("conv_done", bus.conv_done, e_done);
            chk("s_ready_x", bus.s_ready_x, e_rx);
            chk("s_ready_f", bus.s_ready_f, e_rf);
            acc_x = bus.s_valid_x && e_rx;
            acc_f = bus.s_valid_f && e_rf;
            chk("x_wr_en", bus.x_wr_en, acc_x);
            chk("f_wr_en", bus.f_wr_en, acc_f);
            if (acc_f)
                chk("f_addr", bus.f_addr, fa);

            hs = e_mv && bus.m_ready_y;
            xa += int'(acc_x);
            fa += int'(acc_f);
            ycap += int'(e_cap);
            yhs  += int'(hs);
            owed = avail(xa, fa) - ycap;
            trig = (hs || ((acc_x || acc_f) && !e_mv)) && owed > 0;
            done_due = hs && (yhs == NY);

            if (e_done) begin
                chk("job_y_count", yhs, NY);
                chk("job_cap_count", ycap, NY);
                chk("job_x_count", xa, X);
                jobs++;
                xa = 0; fa = 0; ycap = 0; yhs = 0;
            end
            p_cap = e_cap;
            p_mv  = e_mv;
            p_my  = bus.m_ready_y;
        end
    end

    typedef struct {
        bit rst, vx, vf, my;
        bit rx, rf, xw, fw;
        int fad;
        bit cap, mv, dn;
    } vec_t;

    vec_t tbl[6];
    int   jobs_exp = 0;

    task automatic run_job(input int mode);
        int start = jobs;
        int n = 0;
        int hold = 0;
        jobs_exp++;
        while (jobs == start && n < 6000) begin
            @(posedge clk);
            #1;
            n++;
            case (mode)
                0: begin
                    bus.s_valid_x = 1; bus.s_valid_f = 1; bus.m_ready_y = 1;
                end
                2: begin
                    bus.s_valid_f = 1; bus.s_valid_x = (fa == F);
                    bus.m_ready_y = 1;
                end
                3: begin
                    bus.s_valid_x = 1; bus.s_valid_f = 1;
                    if (bus.m_valid_y && hold < 10) begin
                        bus.m_ready_y = 0;
                        hold++;
                    end else begin
                        bus.m_ready_y = 1;
                    end
                end
                4: begin
                    bus.s_valid_f = 1; bus.m_ready_y = 1;
                    bus.s_valid_x = ($urandom % 8 == 0);
                end
                default: begin
                    bus.s_valid_x = ($urandom % 4 != 0);
                    bus.s_valid_f = ($urandom % 2 == 0);
                    bus.m_ready_y = ($urandom % 2 == 0);
                end
            endcase
        end
        chk("job_finished_in_budget", int'(jobs > start), 1);
    endtask

    initial begin
        int n;
        bus.s_valid_x = 0;
        bus.s_valid_f = 0;
        bus.m_ready_y = 0;

        tbl[0] = '{1,1,1,1, 0,0,0,0, 0, 0,0,0};
        tbl[1] = '{0,0,0,0, 1,1,0,0, 0, 0,0,0};
        tbl[2] = '{0,1,0,0, 1,1,1,0, 0, 0,0,0};
        tbl[3] = '{0,0,1,0, 1,1,0,1, 0, 0,0,0};
        tbl[4] = '{0,1,1,0, 1,1,1,1, 1, 0,0,0};
        tbl[5] = '{0,0,1,1, 1,1,0,1, 2, 0,0,0};

        repeat (2) @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            reset         = tbl[i].rst;
            bus.s_valid_x = tbl[i].vx;
            bus.s_valid_f = tbl[i].vf;
            bus.m_ready_y = tbl[i].my;
            @(negedge clk);
            chk("tbl_ready_x", bus.s_ready_x, tbl[i].rx);
            chk("tbl_ready_f", bus.s_ready_f, tbl[i].rf);
            chk("tbl_x_wr", bus.x_wr_en, tbl[i].xw);
            chk("tbl_f_wr", bus.f_wr_en, tbl[i].fw);
            chk("tbl_f_addr", bus.f_addr, tbl[i].fad);
            chk("tbl_cap", bus.y_capture_en, tbl[i].cap);
            chk("tbl_m_valid", bus.m_valid_y, tbl[i].mv);
            chk("tbl_done", bus.conv_done, tbl[i].dn);
        end

        @(posedge clk);
        #1 reset = 1;
        @(posedge clk);
        #1 reset = 0;

        run_job(0);
        run_job(2);
        run_job(3);

        // abort a job while a Y is pending, then run a clean one
        n = 0;
        while (!(yhs == 40 && bus.m_valid_y) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            bus.s_valid_x = 1; bus.s_valid_f = 1; bus.m_ready_y = 1;
            if (yhs == 40) bus.m_ready_y = 0;
        end
        chk("reach_y40", int'(yhs == 40 && bus.m_valid_y), 1);
        reset = 1;
        @(posedge clk);
        #1 reset = 0;
        run_job(0);

        run_job(4);
        for (int j = 0; j < 3; j++)
            run_job(1);

        @(posedge clk);
        #1;
        chk("jobs_total", jobs, jobs_exp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
